ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//   EX-stage iterative multiply/divide unit with architectural HI/LO registers.
//   - Operands are the forwarded ALU inputs (op_a = post-forward rs, op_b = post-forward rt).
//   - Executes MULT/MULTU/DIV/DIVU over multiple cycles while younger instructions proceed.
//   - Raises a stall to hazard control only when a dependent HI/LO or mul/div instruction reaches EX.
// PARAMETERS
//   WIDTH   32               operand width; HI/LO are WIDTH each
//   CNT_W   $clog2(WIDTH)+1  iteration counter width
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      reset, asynchronous, active-high
//   ex_valid   in   1      valid, unflushed instruction in EX
//   ex_kill    in   1      exception flush; aborts any op in flight
//   ex_opcode  in   6      EX instruction opcode
//   ex_funct   in   6      EX instruction funct
//   op_a       in   WIDTH  forwarded rs value
//   op_b       in   WIDTH  forwarded rt value
//   md_stall   out  1      hold IF/ID/EX this cycle
//   md_busy    out  1      iteration in progress
//   md_done    out  1      one-cycle pulse: HI/LO just updated by mul/div
//   mf_data    out  WIDTH  MFHI/MFLO result into EX result mux
//   hi_o       out  WIDTH  HI register
//   lo_o       out  WIDTH  LO register
// BEHAVIOUR
//   - Decode, only when ex_opcode==6'b000000 (R-type); funct values:
//     MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011,
//     MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
//   - Reset: state IDLE; HI, LO, counter, md_busy, md_done all 0.
//   - FSM IDLE -> RUN -> FIX -> IDLE.
//     * IDLE: accept when ex_valid & mul/div funct & !ex_kill & !md_stall.
//       Latch |op_a|, |op_b| (signed ops only), result sign, remainder sign, op kind; counter=0.
//     * RUN: exactly WIDTH cycles, one radix-2 step per cycle.
//       Multiply is shift-add into a 2*WIDTH accumulator; divide is restoring.
//     * FIX: one cycle; sign correction (two's-complement negate) for signed ops.
//       HI/LO are written at the edge ending FIX.
//   - Timing: accept in cycle T; md_busy=1 in T+1..T+33; md_done=1 and state IDLE in T+34.
//     Result latency is 34 cycles.
//   - md_stall = md_busy & ex_valid & funct in {MF*, MT*, MULT*, DIV*}.
//     It is combinational and never depends on md_stall itself.
//   - Results:
//     * MULT/MULTU: {HI,LO} = full 2*WIDTH product.
//     * DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder (takes sign of dividend).
//   - Divide by zero, no trap: LO = all-ones, HI = op_a (original, unsigned or signed).
//   - Signed 0x80000000 / -1: LO = 0x80000000, HI = 0.
//   - MTHI/MTLO: write op_a to HI/LO at the edge ending the EX cycle, only if ex_valid & !ex_kill & !md_stall.
//   - MFHI/MFLO: mf_data = current HI/LO combinationally. MT in cycle N is visible to MF in cycle N+1.
//   - mf_data = 0 for any other instruction.
//   - ex_kill:
//     * Forces IDLE at the next edge; HI/LO unchanged; md_done stays 0.
//     * Blocks acceptance and MT writes in the same cycle.
//     * Priority: kill > done.
//   - Kill arriving in the FIX cycle still aborts; HI/LO are not written.
//   - Asynchronous reset mid-operation: everything returns to its reset values immediately.
// STRUCTURE
//   - Shared package mips_md_pkg: funct localparams above, R-type opcode, FSM state encoding (2 bits).
//   - Sub-module md_iter_step: combinational single-iteration datapath.
//     Inputs: accumulator, operand, mode. Outputs: next accumulator and quotient bit.
//   - Top level holds the FSM, counter, operand/sign latches, HI/LO and the stall logic.
// TESTING
//   1. Reset: assert rst mid-RUN -> md_busy=0, HI=LO=0, state IDLE with no clock edge required.
//   2. MULT -3 x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; md_done in T+34.
//      MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
//   3. DIVU 100/7 -> LO=14, HI=2.
//      DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//      DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//   4. Divide by zero: DIVU 0x1234/0 -> LO=0xFFFFFFFF, HI=0x1234, no stall beyond normal latency.
//   5. Interlock: MULT 6x7 then MFLO next cycle -> md_stall=1 for 33 cycles, then mf_data=42.
//      Unrelated ADD behind MULT -> md_stall=0.
//   6. ex_kill in RUN cycle 10 after a prior MTLO 5 -> IDLE next cycle, no md_done, LO stays 5.
//      MTLO 9 then MFLO next cycle -> mf_data=9.

Source files
------------

// File: rtl/mips_md_pkg.sv
// Shared decode constants and FSM encoding for the EX-stage multiply/divide unit.
package mips_md_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdState_t;

    function automatic logic isMulDivFunct(input logic [5:0] funct);
        return funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

    // Every funct that touches HI/LO or the iterative unit must wait while it is busy.
    function automatic logic isHiLoDepFunct(input logic [5:0] funct);
        return funct inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                             FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    endfunction

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on a 2*WIDTH accumulator.
module md_iter_step
    import mips_md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               isDiv,
    output logic [2*WIDTH-1:0] accNext,
    output logic               qBit
);

    logic [WIDTH:0] mulSum;
    logic [WIDTH:0] divPartial;
    logic [WIDTH:0] divTrial;

    always_comb begin
        mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        divPartial = acc[2*WIDTH-1:WIDTH-1];
        divTrial   = divPartial - {1'b0, operand};
        accNext    = '0;
        qBit       = 1'b0;
        if (isDiv) begin
            // Quotient bit is returned separately; the LSB slot is left at zero for it.
            qBit    = ~divTrial[WIDTH];
            accNext = {(qBit ? divTrial[WIDTH-1:0] : divPartial[WIDTH-1:0]),
                       acc[WIDTH-2:0], 1'b0};
        end else begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit owning the architectural HI/LO registers.
//   state | meaning
//   IDLE  | no op in flight; accepts MULT/DIV, MT* writes allowed
//   RUN   | WIDTH radix-2 iterations on magnitudes
//   FIX   | sign correction; HI/LO written at the closing edge unless killed
module ex_muldiv_unit
    import mips_md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_kill,
    input  logic [5:0]       ex_opcode,
    input  logic [5:0]       ex_funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             md_stall,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdState_t           state, stateNext;
    logic [CNT_W-1:0]   iterCnt;
    logic [2*WIDTH-1:0] acc, accStep, prodFix;
    logic [WIDTH-1:0]   operand, hiReg, loReg, hiRes, loRes, absA, absB;
    logic               isDiv, negRes, negRem, divZero, qBit;
    logic               rType, signedOp, aNeg, bNeg, accept, mtWrite;

    assign rType    = (ex_opcode == OPC_RTYPE);
    assign md_busy  = (state == ST_RUN) || (state == ST_FIX);
    assign md_stall = md_busy & ex_valid & rType & isHiLoDepFunct(ex_funct);
    assign accept   = (state == ST_IDLE) & ex_valid & rType & isMulDivFunct(ex_funct)
                      & ~ex_kill & ~md_stall;
    assign mtWrite  = ex_valid & rType & ~ex_kill & ~md_stall
                      & ((ex_funct == FN_MTHI) || (ex_funct == FN_MTLO));

    assign signedOp = (ex_funct == FN_MULT) || (ex_funct == FN_DIV);
    assign aNeg     = signedOp & op_a[WIDTH-1];
    assign bNeg     = signedOp & op_b[WIDTH-1];
    assign absA     = aNeg ? -op_a : op_a;
    assign absB     = bNeg ? -op_b : op_b;

    md_iter_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc),
        .operand (operand),
        .isDiv   (isDiv),
        .accNext (accStep),
        .qBit    (qBit)
    );

    // Divide-by-zero leaves |a| in the remainder, so the normal sign fix restores op_a in HI.
    assign prodFix = negRes ? -acc : acc;
    assign hiRes   = isDiv ? (negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH])
                           : prodFix[2*WIDTH-1:WIDTH];
    assign loRes   = isDiv ? (divZero ? '1 : (negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]))
                           : prodFix[WIDTH-1:0];

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (accept) stateNext = ST_RUN;
            ST_RUN:  if (iterCnt == CNT_W'(WIDTH - 1)) stateNext = ST_FIX;
            ST_FIX:  stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
        if (ex_kill) stateNext = ST_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            iterCnt <= '0;
            acc     <= '0;
            operand <= '0;
            isDiv   <= 1'b0;
            negRes  <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
            md_done <= 1'b0;
        end else begin
            state   <= stateNext;
            md_done <= (state == ST_FIX) && !ex_kill;
            if (accept) begin
                acc     <= {{WIDTH{1'b0}}, absA};
                operand <= absB;
                iterCnt <= '0;
                isDiv   <= ex_funct[1];
                negRes  <= aNeg ^ bNeg;
                negRem  <= aNeg;
                divZero <= ex_funct[1] && (op_b == '0);
            end else if (state == ST_RUN) begin
                acc     <= {accStep[2*WIDTH-1:1], accStep[0] | qBit};
                iterCnt <= iterCnt + CNT_W'(1);
            end
            if (state == ST_FIX && !ex_kill) begin
                hiReg <= hiRes;
                loReg <= loRes;
            end else if (mtWrite) begin
                if (ex_funct == FN_MTHI) hiReg <= op_a;
                else                     loReg <= op_a;
            end
        end
    end

    always_comb begin
        mf_data = '0;
        if (rType && ex_funct == FN_MFHI) mf_data = hiReg;
        if (rType && ex_funct == FN_MFLO) mf_data = loReg;
    end

    assign hi_o = hiReg;
    assign lo_o = loReg;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed and randomized checks of ex_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_ex_muldiv_unit;

    localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001, MFLO = 6'b010010, MTLO = 6'b010011;
    localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001, DIV = 6'b011010, DIVU = 6'b011011;
    localparam logic [5:0] ADD  = 6'b100000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0, ex_kill = 1'b0;
    logic [5:0]  ex_opcode = 6'd0, ex_funct = ADD;
    logic [31:0] op_a = '0, op_b = '0;
    logic        md_stall, md_busy, md_done;
    logic [31:0] mf_data, hi_o, lo_o;

    int nVec = 0;
    int nMis = 0;

    ex_muldiv_unit dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_kill(ex_kill),
        .ex_opcode(ex_opcode), .ex_funct(ex_funct), .op_a(op_a), .op_b(op_b),
        .md_stall(md_stall), .md_busy(md_busy), .md_done(md_done),
        .mf_data(mf_data), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Reference: {HI,LO} from the architectural rules using native 64-bit arithmetic.
    function automatic logic [63:0] refMd(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        int q, m;
        r = '0;
        case (f)
            MULT:  r = 64'(longint'($signed(a)) * longint'($signed(b)));
            MULTU: r = {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    m = $signed(a) % $signed(b);
                    r = {m, q};
                end
            end
            DIVU: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else r = {a % b, a / b};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        ex_valid = 1'b1; ex_opcode = 6'd0; ex_funct = f; op_a = a; op_b = b;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_funct = ADD;
    endtask

    task automatic runMd(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int n;
        e = refMd(f, a, b);
        issue(f, a, b);
        tick();
        idle();
        n = 1;
        chk({tag, ".busy"}, 64'(md_busy), 64'd1);
        while (!md_done && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'd34);
        chk({tag, ".hilo"}, {hi_o, lo_o}, e);
        chk({tag, ".idle"}, 64'(md_busy), 64'd0);
    endtask

    initial begin
        logic [31:0] hiSave, a, b;
        logic [5:0]  f;
        int n, doneSeen;

        // Reset state
        #12;
        chk("rst.busy", 64'(md_busy), 64'd0);
        chk("rst.done", 64'(md_done), 64'd0);
        chk("rst.hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed arithmetic
        runMd("mult_m3x7",  MULT,  32'hFFFF_FFFD, 32'd7);
        runMd("multu_max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runMd("divu_100_7", DIVU,  32'd100, 32'd7);
        runMd("div_m7_2",   DIV,   32'hFFFF_FFF9, 32'd2);
        runMd("div_ovf",    DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        runMd("divu_zero",  DIVU,  32'h1234, 32'd0);
        runMd("div_negzero", DIV,  32'hFFFF_FF00, 32'd0);

        // Interlock: MFLO right behind MULT
        issue(MULT, 32'd6, 32'd7);
        tick();
        ex_funct = MFLO;
        #2;
        n = 0;
        while (md_stall && n < 50) begin
            n++;
            tick();
            #2;
        end
        chk("ilk.stall_cycles", 64'(n), 64'd33);
        chk("ilk.mflo", 64'(mf_data), 64'd42);
        chk("ilk.done", 64'(md_done), 64'd1);
        idle();

        // Unrelated ADD behind MULT does not stall
        tick();
        issue(MULT, 32'd3, 32'd5);
        tick();
        ex_funct = ADD;
        #2;
        chk("add.stall", 64'(md_stall), 64'd0);
        chk("add.mfdata", 64'(mf_data), 64'd0);
        idle();
        n = 1;
        while (!md_done && n < 40) begin tick(); n++; end
        chk("add.lo", 64'(lo_o), 64'd15);

        // MTLO 5 then MFLO sees it next cycle
        issue(MTLO, 32'd5, 32'd0);
        tick();
        ex_funct = MFLO;
        #2;
        chk("mtlo5.mflo", 64'(mf_data), 64'd5);
        idle();

        // Kill in RUN cycle 10
        tick();
        issue(MULT, 32'd6, 32'd7);
        tick();
        idle();
        for (int i = 1; i < 10; i++) tick();
        ex_kill = 1'b1;
        tick();
        ex_kill = 1'b0;
        chk("kill_run.busy", 64'(md_busy), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (md_done) doneSeen++;
        end
        chk("kill_run.no_done", 64'(doneSeen), 64'd0);
        chk("kill_run.lo", 64'(lo_o), 64'd5);

        // Kill in the FIX cycle
        hiSave = hi_o;
        issue(DIVU, 32'd100, 32'd7);
        tick();
        idle();
        for (int i = 1; i < 33; i++) tick();
        chk("kill_fix.busy", 64'(md_busy), 64'd1);
        ex_kill = 1'b1;
        tick();
        ex_kill = 1'b0;
        chk("kill_fix.done", 64'(md_done), 64'd0);
        chk("kill_fix.hilo", {hi_o, lo_o}, {hiSave, 32'd5});

        // Kill blocks MT writes and acceptance in the same cycle
        issue(MTLO, 32'd77, 32'd0);
        ex_kill = 1'b1;
        tick();
        chk("kill_mt.lo", 64'(lo_o), 64'd5);
        issue(MULT, 32'd2, 32'd2);
        tick();
        ex_kill = 1'b0;
        idle();
        chk("kill_acc.busy", 64'(md_busy), 64'd0);

        // MTLO 9 then MFLO
        issue(MTLO, 32'd9, 32'd0);
        tick();
        ex_funct = MFLO;
        #2;
        chk("mtlo9.mflo", 64'(mf_data), 64'd9);
        issue(MTHI, 32'hCAFE_0001, 32'd0);
        tick();
        ex_funct = MFHI;
        #2;
        chk("mthi.mfhi", 64'(mf_data), 64'hCAFE_0001);
        idle();
        tick();

        // Randomized ops against the reference model
        for (int k = 0; k < 20; k++) begin
            case ($urandom_range(0, 3))
                0: f = MULT;
                1: f = MULTU;
                2: f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 15));
                1: b = 32'd0;
                2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            runMd("rand", f, a, b);
        end

        // Asynchronous reset mid-RUN
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick();
        idle();
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst.busy", 64'(md_busy), 64'd0);
        chk("arst.hilo", {hi_o, lo_o}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        runMd("post_rst", MULT, 32'hFFFF_FFFD, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
